// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: decoder controls, forwarded operands and HI/LO/busy results of the MD unit
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  MDop;
    logic        HIwrite;
    logic        LOwrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output start, MDop, HIwrite, LOwrite, A, B, input busy, HI, LO);
    modport slave  (input start, MDop, HIwrite, LOwrite, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/multu/div/divu with HI/LO registers and mthi/mtlo writes
// MD_DIV0_DEFINED_EN: divide by zero commits LO=all ones, HI=A; otherwise HI/LO are left unchanged
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [4:0] MC = 5'(MULT_CYCLES);
    localparam logic [4:0] DC = 5'(DIV_CYCLES);
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic        wr_q, wr_d;
    logic        is_div, sgn, div0, done, launch;
    logic [63:0] prod_u, prod_s;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    assign is_div = md.MDop[1];
    assign sgn    = md.MDop[0];
    assign div0   = is_div && md.B == 32'd0;
    assign launch = md.start && !md.MDop[2];
    assign done   = state_q == RUN && cnt_q == 5'd1;
    assign prod_u = {32'd0, md.A} * {32'd0, md.B};
    assign prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    // sign-magnitude division keeps 0x80000000 / -1 well defined
    assign a_neg  = sgn && md.A[31];
    assign b_neg  = sgn && md.B[31];
    assign a_mag  = a_neg ? 32'd0 - md.A : md.A;
    assign b_mag  = b_neg ? 32'd0 - md.B : md.B;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign quo    = (a_neg ^ b_neg) ? 32'd0 - q_mag : q_mag;
    assign rem    = a_neg ? 32'd0 - r_mag : r_mag;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        wr_d    = wr_q;
        if (state_q == RUN) begin
            cnt_d = cnt_q - 5'd1;
            if (done) begin
                state_d = IDLE;
                hi_d    = wr_q ? hi_n_q : hi_q;
                lo_d    = wr_q ? lo_n_q : lo_q;
            end
        end
        // a start in the completion cycle chains straight into the next operation
        if ((state_q == IDLE || done) && launch) begin
            state_d = RUN;
            cnt_d   = is_div ? DC : MC;
            hi_n_d  = is_div ? rem : (sgn ? prod_s[63:32] : prod_u[63:32]);
            lo_n_d  = is_div ? quo : (sgn ? prod_s[31:0] : prod_u[31:0]);
`ifdef MD_DIV0_DEFINED_EN
            hi_n_d  = div0 ? md.A : hi_n_d;
            lo_n_d  = div0 ? 32'hFFFF_FFFF : lo_n_d;
            wr_d    = 1'b1;
`else
            wr_d    = !div0;
`endif
        end else if (state_q == IDLE && !md.start) begin
            hi_d = md.HIwrite ? md.A : hi_q;
            lo_d = md.LOwrite ? md.A : lo_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            wr_q    <= wr_d;
        end
    end
    assign md.busy = state_q == RUN;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit timing, arithmetic, priorities and reset
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    int cycles;
    logic held;
    mult_div_unit_if md();
    mult_div_unit dut (.clk(clk), .reset(reset), .md(md));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic mt(input logic hw, input logic lw, input logic [31:0] a);
        md.HIwrite = hw;
        md.LOwrite = lw;
        md.A = a;
        tick();
        md.HIwrite = 1'b0;
        md.LOwrite = 1'b0;
    endtask
    task automatic op(input string tag, input logic [2:0] mdop, input logic [31:0] a, input logic [31:0] b,
                      input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                      input logic [31:0] new_hi, input logic [31:0] new_lo);
        md.start = 1'b1;
        md.MDop = mdop;
        md.A = a;
        md.B = b;
        tick();
        md.start = 1'b0;
        cycles = 0;
        held = 1'b1;
        while (md.busy && cycles < 40) begin
            if (md.HI !== old_hi || md.LO !== old_lo) held = 1'b0;
            cycles++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(cycles), 32'(n));
        chk({tag, "_old_held"}, {31'd0, held}, 32'd1);
        chk({tag, "_hi"}, md.HI, new_hi);
        chk({tag, "_lo"}, md.LO, new_lo);
    endtask
    initial begin
        md.start = 1'b0;
        md.MDop = 3'b000;
        md.HIwrite = 1'b0;
        md.LOwrite = 1'b0;
        md.A = '0;
        md.B = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, md.busy}, 32'd0);
        chk("rst_hi", md.HI, 32'd0);
        chk("rst_lo", md.LO, 32'd0);
        mt(1'b1, 1'b0, 32'h1234_5678);
        chk("mthi", md.HI, 32'h1234_5678);
        chk("mthi_lo_kept", md.LO, 32'd0);
        mt(1'b0, 1'b1, 32'h9ABC_DEF0);
        chk("mtlo", md.LO, 32'h9ABC_DEF0);
        op("mult", 3'b001, 32'hFFFF_FFFF, 32'd2, 5, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op("multu", 3'b000, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
        op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op("divu", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);
        op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0001, 32'h7FFF_FFFC, 32'd0, 32'h8000_0000);
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        chk("mt_both_hi", md.HI, 32'h11);
`ifdef MD_DIV0_DEFINED_EN
        op("div0", 3'b011, 32'd5, 32'd0, 10, 32'h11, 32'h22, 32'h5, 32'hFFFF_FFFF);
`else
        op("div0", 3'b011, 32'd5, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);
`endif
        mt(1'b1, 1'b1, 32'h55);
        chk("mt_dual_hi", md.HI, 32'h55);
        chk("mt_dual_lo", md.LO, 32'h55);
        md.start = 1'b1;
        md.MDop = 3'b001;
        md.A = 32'd3;
        md.B = 32'd4;
        tick();
        md.start = 1'b0;
        cycles = 0;
        while (md.busy && cycles < 40) begin
            md.start = cycles == 1;
            md.HIwrite = cycles == 1;
            md.MDop = cycles == 1 ? 3'b011 : 3'b001;
            md.A = cycles == 1 ? 32'hDEAD : 32'd3;
            md.B = cycles == 1 ? 32'd1 : 32'd4;
            cycles++;
            tick();
        end
        md.start = 1'b0;
        md.HIwrite = 1'b0;
        chk("illegal_busy_cycles", 32'(cycles), 32'd5);
        chk("illegal_hi", md.HI, 32'd0);
        chk("illegal_lo", md.LO, 32'd12);
        tick();
        chk("illegal_no_restart", {31'd0, md.busy}, 32'd0);
        md.start = 1'b1;
        md.MDop = 3'b101;
        tick();
        md.start = 1'b0;
        chk("rsvd_busy", {31'd0, md.busy}, 32'd0);
        chk("rsvd_lo", md.LO, 32'd12);
        md.start = 1'b1;
        md.MDop = 3'b000;
        md.A = 32'h0001_0000;
        md.B = 32'h0001_0000;
        tick();
        md.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", {31'd0, md.busy}, 32'd0);
        chk("midrst_hi", md.HI, 32'd0);
        chk("midrst_lo", md.LO, 32'd0);
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) held = 1'b0;
        end
        chk("midrst_stay_zero", {31'd0, held}, 32'd1);
        md.start = 1'b1;
        md.MDop = 3'b001;
        md.A = 32'd3;
        md.B = 32'd4;
        tick();
        md.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_busy_last", {31'd0, md.busy}, 32'd1);
        md.start = 1'b1;
        md.MDop = 3'b000;
        md.A = 32'hFFFF_FFFF;
        md.B = 32'hFFFF_FFFF;
        tick();
        md.start = 1'b0;
        chk("b2b_busy_cont", {31'd0, md.busy}, 32'd1);
        chk("b2b_first_lo", md.LO, 32'd12);
        chk("b2b_first_hi", md.HI, 32'd0);
        cycles = 0;
        while (md.busy && cycles < 40) begin
            cycles++;
            tick();
        end
        chk("b2b_second_cycles", 32'(cycles), 32'd5);
        chk("b2b_second_hi", md.HI, 32'hFFFF_FFFE);
        chk("b2b_second_lo", md.LO, 32'h0000_0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
